rej_uniform_sampler: RTL and testbench

Rejection sampler (Kyber Parse) that consumes squeezed sponge rate blocks and emits 256 uniform coefficients mod q. It sits downstream of the SHAKE128 sponge in matrix-A generation. It pulls one rate block at a time through a valid/ready handshake and requests a further squeeze whenever a block is exhausted before 256 coefficients have been accepted. It streams coefficients to the NTT-domain matrix buffer.

---
 rtl/kyber_pkg.sv | 25 ++
 rtl/rej_triple_decode.sv | 19 +
 rtl/rej_uniform_sampler.sv | 137 +++++++++++++
 tb/tb_rej_uniform_sampler.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kyber_pkg.sv
// Shared Kyber constants, coefficient type and sampler state encoding
// used along the matrix-A generation path.
package kyber_pkg;

   localparam int unsigned KYBER_Q           = 32'd3329;
   localparam int unsigned KYBER_N           = 32'd256;
   localparam int unsigned SHAKE128_RATE     = 32'd1344;
   localparam int unsigned TRIPLES_PER_BLOCK = SHAKE128_RATE / 32'd24;

   typedef logic [11:0] coeff_t;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WAIT_BLK = 3'd1,
      PARSE    = 3'd2,
      REQ      = 3'd3,
      DONE     = 3'd4
   } sampler_state_e;

   // A candidate survives rejection only when strictly below q.
   function automatic logic coeff_below_q(input coeff_t c);
      return (c < 12'(KYBER_Q));
   endfunction

endpackage

// File: rtl/rej_triple_decode.sv
// Splits one 3-byte group {b2,b1,b0} into the two 12-bit Parse candidates
// and flags which of them fall below q.
module rej_triple_decode
   import kyber_pkg::*;
(
   input  logic [23:0] triple,
   output coeff_t      d1,
   output coeff_t      d2,
   output logic        d1_ok,
   output logic        d2_ok
);

   // d1 = b0 + 256*(b1 mod 16) and d2 = b1/16 + 16*b2 are plain bit fields.
   assign d1    = triple[11:0];
   assign d2    = triple[23:12];
   assign d1_ok = coeff_below_q(d1);
   assign d2_ok = coeff_below_q(d2);

endmodule

// File: rtl/rej_uniform_sampler.sv
// Kyber Parse rejection sampler: pulls squeezed rate blocks and streams
// 256 coefficients below q, requesting a new squeeze when a block runs dry.
module rej_uniform_sampler
   import kyber_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [SHAKE128_RATE-1:0] block_in,
   input  logic                     block_valid,
   output logic                     block_ready,
   output logic                     squeeze_req,
   output coeff_t                   coeff_out,
   output logic [7:0]               coeff_idx,
   output logic                     coeff_valid,
   input  logic                     coeff_ready,
   output logic                     busy,
   output logic                     done
);

   localparam logic [5:0] LAST_TRIPLE = 6'(TRIPLES_PER_BLOCK - 32'd1);
   localparam logic [8:0] LAST_COUNT  = 9'(KYBER_N - 32'd1);

   sampler_state_e           state_r, state_nx_s;
   logic [SHAKE128_RATE-1:0] blk_r;
   logic [5:0]               triple_r, triple_nx_s;
   logic                     half_r, half_nx_s;
   logic [8:0]               count_r, count_nx_s;
   logic                     load_blk_s;
   logic [10:0]              bit_base_s;
   logic [23:0]              triple_bits_s;
   coeff_t                   d1_s, d2_s, cand_s;
   logic                     d1_ok_s, d2_ok_s, cand_ok_s;
   logic                     take_s, advance_s;

   assign bit_base_s    = 11'(triple_r) * 11'd24;
   assign triple_bits_s = blk_r[bit_base_s +: 24];

   rej_triple_decode u_decode (
      .triple (triple_bits_s),
      .d1     (d1_s),
      .d2     (d2_s),
      .d1_ok  (d1_ok_s),
      .d2_ok  (d2_ok_s)
   );

   assign cand_s    = half_r ? d2_s : d1_s;
   assign cand_ok_s = half_r ? d2_ok_s : d1_ok_s;

   // Outputs decode from registered state, so stalls cannot disturb them.
   assign coeff_valid = (state_r == PARSE) && cand_ok_s;
   assign coeff_out   = coeff_valid ? cand_s : 12'd0;
   assign coeff_idx   = count_r[7:0];
   assign block_ready = (state_r == WAIT_BLK);
   assign squeeze_req = (state_r == REQ);
   assign done        = (state_r == DONE);
   assign busy        = (state_r == WAIT_BLK) || (state_r == PARSE) || (state_r == REQ);

   assign take_s    = coeff_valid && coeff_ready;
   assign advance_s = take_s || !cand_ok_s;

   // Next-state, pointer and counter decisions.
   always_comb begin
      state_nx_s  = state_r;
      triple_nx_s = triple_r;
      half_nx_s   = half_r;
      count_nx_s  = count_r;
      load_blk_s  = 1'b0;
      case (state_r)
         IDLE, DONE: begin
            if (start) begin
               state_nx_s  = WAIT_BLK;
               count_nx_s  = 9'd0;
               triple_nx_s = 6'd0;
               half_nx_s   = 1'b0;
            end else begin
               state_nx_s  = state_r;
            end
         end
         WAIT_BLK: begin
            if (block_valid) begin
               load_blk_s  = 1'b1;
               triple_nx_s = 6'd0;
               half_nx_s   = 1'b0;
               state_nx_s  = PARSE;
            end else begin
               state_nx_s  = WAIT_BLK;
            end
         end
         PARSE: begin
            if (take_s && (count_r == LAST_COUNT)) begin
               count_nx_s = count_r + 9'd1;
               state_nx_s = DONE;
            end else if (advance_s) begin
               count_nx_s = take_s ? (count_r + 9'd1) : count_r;
               if (!half_r) begin
                  half_nx_s = 1'b1;
               end else if (triple_r == LAST_TRIPLE) begin
                  state_nx_s = REQ;
               end else begin
                  half_nx_s   = 1'b0;
                  triple_nx_s = triple_r + 6'd1;
               end
            end else begin
               state_nx_s = PARSE;
            end
         end
         REQ:     state_nx_s = WAIT_BLK;
         default: state_nx_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Block buffer, candidate pointer and accepted-coefficient count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blk_r    <= '0;
         triple_r <= 6'd0;
         half_r   <= 1'b0;
         count_r  <= 9'd0;
      end else begin
         blk_r    <= load_blk_s ? block_in : blk_r;
         triple_r <= triple_nx_s;
         half_r   <= half_nx_s;
         count_r  <= count_nx_s;
      end
   end

endmodule

// File: tb/tb_rej_uniform_sampler.sv
// Self-checking bench for rej_uniform_sampler: a byte-level Parse model
// predicts coefficients and squeeze counts for each scenario.
module tb_rej_uniform_sampler;

   typedef logic [1343:0] blk_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   blk_t       block_in = '0;
   logic       block_valid = 1'b0;
   logic       block_ready;
   logic       squeeze_req;
   logic [11:0] coeff_out;
   logic [7:0] coeff_idx;
   logic       coeff_valid;
   logic       coeff_ready = 1'b0;
   logic       busy;
   logic       done;

   rej_uniform_sampler dut (
      .clk(clk), .rst_n(rst_n), .start(start), .block_in(block_in),
      .block_valid(block_valid), .block_ready(block_ready), .squeeze_req(squeeze_req),
      .coeff_out(coeff_out), .coeff_idx(coeff_idx), .coeff_valid(coeff_valid),
      .coeff_ready(coeff_ready), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   blk_t blocks_q[$];
   int   exp_c[$];
   int   exp_sq;
   int   xfer_c[$], xfer_i[$], xfer_cyc[$], acc_cyc[$], sq_cyc[$];
   bit   saw_done, timed_out, busy_at_done, ready_at_start;
   int   done_cyc, hold_err, req_ready_err, busy_err;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic blk_t fill_block(input logic [7:0] b);
      blk_t r;
      for (int k = 0; k < 168; k++) r[8*k +: 8] = b;
      return r;
   endfunction

   function automatic blk_t rand_block();
      blk_t r;
      for (int k = 0; k < 168; k++) r[8*k +: 8] = 8'($urandom);
      return r;
   endfunction

   // Reference: walk bytes in order, apply the Parse rule, stop at 256.
   task automatic build_model();
      int cnt, used, b0, b1, b2, d1, d2;
      blk_t blk;
      cnt = 0; used = 0;
      exp_c.delete();
      for (int b = 0; b < blocks_q.size() && cnt < 256; b++) begin
         used = b + 1;
         blk = blocks_q[b];
         for (int j = 0; j < 56 && cnt < 256; j++) begin
            b0 = int'(blk[24*j +: 8]);
            b1 = int'(blk[24*j+8 +: 8]);
            b2 = int'(blk[24*j+16 +: 8]);
            d1 = b0 + 256 * (b1 % 16);
            d2 = b1 / 16 + 16 * b2;
            if (d1 < 3329) begin exp_c.push_back(d1); cnt++; end
            if (cnt < 256 && d2 < 3329) begin exp_c.push_back(d2); cnt++; end
         end
      end
      exp_sq = used - 1;
   endtask

   function automatic int count_diffs();
      int n;
      n = 0;
      if (xfer_c.size() != exp_c.size()) begin
         n++;
         $display("  note: %0d transfers seen, %0d predicted", xfer_c.size(), exp_c.size());
      end
      for (int i = 0; i < exp_c.size() && i < xfer_c.size(); i++) begin
         if (xfer_c[i] != exp_c[i] || xfer_i[i] != i) begin
            if (n < 4) $display("  note: transfer %0d got %0d@%0d want %0d@%0d", i, xfer_c[i], xfer_i[i], exp_c[i], i);
            n++;
         end
      end
      return n;
   endfunction

   task automatic do_reset();
      start = 1'b0; block_valid = 1'b0; coeff_ready = 1'b0;
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
   endtask

   // Drives one polynomial: feeds blocks_q on demand and records transfers.
   task automatic run_poly(input int ready_pct, input int stop_after, input bit spurious);
      int bi, prev_sq;
      logic [11:0] pc;
      logic [7:0] pi;
      bit stalled;
      xfer_c.delete(); xfer_i.delete(); xfer_cyc.delete(); acc_cyc.delete(); sq_cyc.delete();
      saw_done = 0; timed_out = 0; hold_err = 0; req_ready_err = 0; busy_err = 0;
      done_cyc = 0; busy_at_done = 1'b1; prev_sq = -10; bi = 0; stalled = 0; pc = '0; pi = '0;
      start = 1'b1; tick(); start = 1'b0;
      ready_at_start = block_ready;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         if (done) begin saw_done = 1; done_cyc = cyc; busy_at_done = busy; break; end
         if (!busy) busy_err++;
         if (prev_sq == cyc - 1 && !block_ready) req_ready_err++;
         if (squeeze_req) begin sq_cyc.push_back(cyc); prev_sq = cyc; end
         if (stalled && !(coeff_valid && coeff_out == pc && coeff_idx == pi)) hold_err++;
         block_valid = block_ready && (bi < blocks_q.size());
         if (block_valid) begin block_in = blocks_q[bi]; bi++; acc_cyc.push_back(cyc); end
         coeff_ready = ($urandom_range(0, 99) < ready_pct);
         start = spurious && busy && ($urandom_range(0, 7) == 0);
         stalled = coeff_valid && !coeff_ready;
         pc = coeff_out; pi = coeff_idx;
         if (coeff_valid && coeff_ready) begin
            xfer_c.push_back(int'(coeff_out)); xfer_i.push_back(int'(coeff_idx)); xfer_cyc.push_back(cyc);
         end
         tick();
         if (stop_after > 0 && xfer_c.size() == stop_after) break;
      end
      if (!saw_done && stop_after == 0) timed_out = 1;
      start = 1'b0; block_valid = 1'b0; coeff_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      total++; if ({block_ready, squeeze_req, coeff_out, coeff_idx, coeff_valid, busy, done} !== 25'd0) begin
         bad++; $display("FAIL reset_outputs: got %h want 0", {block_ready, squeeze_req, coeff_out, coeff_idx, coeff_valid, busy, done}); end
      tick(); rst_n = 1'b1; tick();
      total++; if ({block_ready, squeeze_req, coeff_valid, busy, done} !== 5'd0) begin
         bad++; $display("FAIL idle_outputs: got %b want 00000", {block_ready, squeeze_req, coeff_valid, busy, done}); end
   endtask

   task automatic test_zero_blocks();
      do_reset();
      blocks_q = '{fill_block(8'h00), fill_block(8'h00), fill_block(8'h00)};
      build_model();
      run_poly(100, 0, 1'b0);
      total++; if (timed_out) begin bad++; $display("FAIL zero_timeout: got no done want done"); end
      total++; if (count_diffs() != 0) begin bad++; $display("FAIL zero_coeffs: got mismatching stream want model stream"); end
      total++; if (sq_cyc.size() != exp_sq) begin bad++; $display("FAIL zero_squeezes: got %0d want %0d", sq_cyc.size(), exp_sq); end
      total++; if (ready_at_start !== 1'b1) begin bad++; $display("FAIL start_to_ready: got %0b want 1", ready_at_start); end
      total++; if (req_ready_err != 0) begin bad++; $display("FAIL req_to_ready: got %0d late want 0", req_ready_err); end
      total++; if (busy_err != 0 || busy_at_done !== 1'b0) begin bad++; $display("FAIL zero_busy: got %0d/%0b want 0/0", busy_err, busy_at_done); end
      if (xfer_cyc.size() > 0) begin
         total++; if (done_cyc - xfer_cyc[$] != 1) begin bad++; $display("FAIL done_latency: got %0d want 1", done_cyc - xfer_cyc[$]); end
      end
   endtask

   task automatic test_first_values();
      blk_t b;
      do_reset();
      b = rand_block();
      b[23:0] = 24'h030201;
      blocks_q = '{b, rand_block(), rand_block(), rand_block(), rand_block(), rand_block()};
      build_model();
      run_poly(100, 0, 1'b0);
      total++; if (count_diffs() != 0) begin bad++; $display("FAIL first_coeffs: got mismatching stream want model stream"); end
      total++; if (sq_cyc.size() != exp_sq) begin bad++; $display("FAIL first_squeezes: got %0d want %0d", sq_cyc.size(), exp_sq); end
      if (xfer_c.size() < 2 || acc_cyc.size() < 1) begin
         total++; bad++; $display("FAIL first_count: got %0d want >=2", xfer_c.size());
      end else begin
         total++; if (xfer_c[0] != 513 || xfer_i[0] != 0) begin bad++; $display("FAIL first_c0: got %0d@%0d want 513@0", xfer_c[0], xfer_i[0]); end
         total++; if (xfer_c[1] != 48 || xfer_i[1] != 1) begin bad++; $display("FAIL first_c1: got %0d@%0d want 48@1", xfer_c[1], xfer_i[1]); end
         total++; if (xfer_cyc[0] - acc_cyc[0] != 1) begin bad++; $display("FAIL accept_to_first: got %0d want 1", xfer_cyc[0] - acc_cyc[0]); end
         total++; if (xfer_cyc[1] - xfer_cyc[0] != 1) begin bad++; $display("FAIL back_to_back: got %0d want 1", xfer_cyc[1] - xfer_cyc[0]); end
      end
   endtask

   task automatic test_all_ff();
      do_reset();
      blocks_q = '{fill_block(8'hFF), fill_block(8'hFF), fill_block(8'hFF),
                   fill_block(8'h00), fill_block(8'h00), fill_block(8'h00)};
      build_model();
      run_poly(100, 0, 1'b0);
      total++; if (count_diffs() != 0) begin bad++; $display("FAIL ff_coeffs: got mismatching stream want model stream"); end
      total++; if (sq_cyc.size() != exp_sq) begin bad++; $display("FAIL ff_squeezes: got %0d want %0d", sq_cyc.size(), exp_sq); end
      if (sq_cyc.size() < 3 || acc_cyc.size() < 4) begin
         total++; bad++; $display("FAIL ff_blocks: got %0d squeezes want >=3", sq_cyc.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            total++; if (sq_cyc[i] - acc_cyc[i] != 113) begin bad++; $display("FAIL ff_req_gap%0d: got %0d want 113", i, sq_cyc[i] - acc_cyc[i]); end
         end
         if (xfer_cyc.size() > 0) begin
            total++; if (xfer_cyc[0] <= acc_cyc[3]) begin bad++; $display("FAIL ff_no_valid: got first transfer %0d want after %0d", xfer_cyc[0], acc_cyc[3]); end
         end
      end
   endtask

   task automatic test_backpressure();
      blk_t b;
      int waited;
      do_reset();
      b = fill_block(8'h00);
      b[23:0] = 24'h030201;
      start = 1'b1; tick(); start = 1'b0;
      block_in = b; block_valid = 1'b1; coeff_ready = 1'b0;
      tick();
      block_valid = 1'b0;
      waited = 0;
      while (!coeff_valid && waited < 20) begin tick(); waited++; end
      total++; if (waited != 0) begin bad++; $display("FAIL bp_first_valid: got %0d cycles want 0", waited); end
      for (int i = 0; i < 5; i++) begin
         total++; if (!coeff_valid || coeff_out != 12'd513 || coeff_idx != 8'd0 || squeeze_req) begin
            bad++; $display("FAIL bp_hold%0d: got %0d@%0d v=%0b want 513@0 v=1", i, coeff_out, coeff_idx, coeff_valid); end
         tick();
      end
      coeff_ready = 1'b1;
      tick();
      coeff_ready = 1'b0;
      total++; if (coeff_out != 12'd48 || coeff_idx != 8'd1) begin bad++; $display("FAIL bp_release: got %0d@%0d want 48@1", coeff_out, coeff_idx); end
      tick();
      total++; if (coeff_out != 12'd48 || coeff_idx != 8'd1) begin bad++; $display("FAIL bp_second_hold: got %0d@%0d want 48@1", coeff_out, coeff_idx); end
   endtask

   task automatic test_reset_mid_parse();
      do_reset();
      blocks_q = '{fill_block(8'h00), fill_block(8'h00), fill_block(8'h00)};
      build_model();
      run_poly(100, 40, 1'b0);
      total++; if (coeff_idx != 8'd40 || !busy) begin bad++; $display("FAIL mid_count: got %0d busy=%0b want 40 busy=1", coeff_idx, busy); end
      #2 rst_n = 1'b0;
      #1;
      total++; if ({block_ready, squeeze_req, coeff_out, coeff_idx, coeff_valid, busy, done} !== 25'd0) begin
         bad++; $display("FAIL mid_reset: got %h want 0", {block_ready, squeeze_req, coeff_out, coeff_idx, coeff_valid, busy, done}); end
      tick(); rst_n = 1'b1; tick();
      run_poly(100, 0, 1'b0);
      total++; if (count_diffs() != 0) begin bad++; $display("FAIL restart_coeffs: got mismatching stream want model stream"); end
      total++; if (sq_cyc.size() != exp_sq) begin bad++; $display("FAIL restart_squeezes: got %0d want %0d", sq_cyc.size(), exp_sq); end
   endtask

   task automatic test_last_candidate();
      blk_t b3;
      int quiet_err;
      do_reset();
      b3 = fill_block(8'hFF);
      for (int k = 120; k < 168; k++) b3[8*k +: 8] = 8'h00;
      blocks_q = '{fill_block(8'h00), fill_block(8'h00), b3, rand_block()};
      build_model();
      run_poly(100, 0, 1'b1);
      total++; if (count_diffs() != 0) begin bad++; $display("FAIL last_coeffs: got mismatching stream want model stream"); end
      total++; if (sq_cyc.size() != exp_sq) begin bad++; $display("FAIL last_squeezes: got %0d want %0d", sq_cyc.size(), exp_sq); end
      if (xfer_cyc.size() == 256 && acc_cyc.size() >= 3) begin
         total++; if (xfer_cyc[255] - acc_cyc[2] != 112) begin bad++; $display("FAIL last_position: got %0d want 112", xfer_cyc[255] - acc_cyc[2]); end
      end
      quiet_err = 0;
      for (int i = 0; i < 4; i++) begin
         if (squeeze_req || !done || block_ready) quiet_err++;
         tick();
      end
      total++; if (quiet_err != 0) begin bad++; $display("FAIL last_quiet: got %0d bad cycles want 0", quiet_err); end
      blocks_q = '{fill_block(8'h00), fill_block(8'h00), fill_block(8'h00)};
      build_model();
      run_poly(100, 0, 1'b0);
      total++; if (count_diffs() != 0) begin bad++; $display("FAIL done_restart: got mismatching stream want model stream"); end
   endtask

   task automatic test_random();
      for (int r = 0; r < 3; r++) begin
         blocks_q.delete();
         for (int k = 0; k < 8; k++) blocks_q.push_back(rand_block());
         build_model();
         run_poly(70, 0, 1'b1);
         total++; if (timed_out) begin bad++; $display("FAIL rand%0d_timeout: got no done want done", r); end
         total++; if (count_diffs() != 0) begin bad++; $display("FAIL rand%0d_coeffs: got mismatching stream want model stream", r); end
         total++; if (sq_cyc.size() != exp_sq) begin bad++; $display("FAIL rand%0d_squeezes: got %0d want %0d", r, sq_cyc.size(), exp_sq); end
         total++; if (hold_err != 0) begin bad++; $display("FAIL rand%0d_hold: got %0d unstable want 0", r, hold_err); end
         total++; if (req_ready_err != 0 || busy_err != 0) begin bad++; $display("FAIL rand%0d_flow: got %0d/%0d want 0/0", r, req_ready_err, busy_err); end
      end
   endtask

   initial begin
      test_reset();
      test_zero_blocks();
      test_first_values();
      test_all_ff();
      test_backpressure();
      test_reset_mid_parse();
      test_last_candidate();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
